t9990_video_out: RTL and testbench
==================================

Name: t9990_video_out

Overview:
- Output stage directly downstream of the tiny9990 palette; consumes its 16-bit colour word {YS, G5, R5, B5}.
- Aligns the raster timing signals (sync, display window, blank) to the palette's pixel latency.
- Substitutes border colour outside the display window, forces black during blanking, and expands 5-bit components to 8 bits.
- Drives registered RGB888 + HS/VS/DE/YS toward the video encoder/HDMI block.

Parameters:
- DELAY, 3, number of DCLK_EN ticks between timing inputs (sampled alongside PA at the palette) and COLOR valid at this block; legal 1..7.

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous active-low reset
- DCLK_EN  in  1  dot-clock enable; all pixel-path state advances only when high
- START  in  1  line start; same pulse as the palette's START, re-aligns the delay line
- COLOR  in  16  palette output: [15]=YS, [14:10]=G, [9:5]=R, [4:0]=B
- BORDER  in  16  border colour word, same format as COLOR; [15] ignored
- HSYNC_IN_n  in  1  horizontal sync, active-low, timed with PA
- VSYNC_IN_n  in  1  vertical sync, active-low, timed with PA
- DISP_IN  in  1  active display window, timed with PA
- BLANK_IN  in  1  blanking interval, timed with PA
- R_OUT  out  8  red
- G_OUT  out  8  green
- B_OUT  out  8  blue
- HSYNC_n  out  1  aligned horizontal sync, active-low
- VSYNC_n  out  1  aligned vertical sync, active-low
- DE  out  1  data enable (= !blank, aligned)
- YS  out  1  superimpose / transparency flag

Behaviour:
- Reset (RESET_n low, asynchronous):
  - R_OUT, G_OUT, B_OUT = 0.
  - HSYNC_n, VSYNC_n = 1; DE = 0; YS = 0.
  - Delay-line contents = {HS=1, VS=1, DISP=0, BLANK=1}; write index = 0.
- Delay line: 8-entry ring holding {HSYNC_IN_n, VSYNC_IN_n, DISP_IN, BLANK_IN}.
  - Write index w advances on DCLK_EN; read index r = w - DELAY (mod 8).
  - START (synchronous, priority over DCLK_EN) resets w to 0; contents are kept.
  - A START on the same cycle as DCLK_EN: index reset wins, no write occurs.
- Output register, one stage, updated only on DCLK_EN. With d = delayed tap:
  - If d.BLANK: RGB = 0, YS = 0, DE = 0.
  - Else if !d.DISP: RGB = expand(BORDER), YS = 0, DE = 1.
  - Else: RGB = expand(COLOR), YS = COLOR[15], DE = 1.
  - HSYNC_n / VSYNC_n = d.HS / d.VS, independent of blank.
- expand(c5) = {c5, c5[4:2]}, so 0 -> 0x00 and 31 -> 0xFF.
- Total latency from a timing input to the output pin: DELAY + 1 DCLK_EN ticks. COLOR to pin: 1 tick.
- DCLK_EN low: all outputs hold.
- BLANK and DISP both high: BLANK wins.
- Index wrap 7 -> 0 is seamless.

Optional Feature:
- Macro: T9990_VOUT_SCANLINE_EN.
- When defined:
  - A 1-bit line parity toggles on each falling edge of aligned d.HS; it is cleared when aligned d.VS is low.
  - On odd lines, each 8-bit component of non-blank pixels is halved (logical shift right 1). Border pixels are halved too.
  - A new input SCANLINE (1 bit) gates the effect; parity resets to 0.
- When undefined: no SCANLINE port, no parity register, output is identical to the base behaviour.

Decomposition:
- Package T9990_REG (shared) gains:
  - typedef of the colour word as a packed struct {ys, g, r, b};
  - typedef of the timing bundle {hs_n, vs_n, disp, blank};
  - localparam VOUT_DLY_DEPTH = 8.
- Sub-module t9990_vout_delay: generic ring-buffer delay of the timing bundle, with ports CLK, RESET_n, EN, START, DIN, DOUT and parameter DELAY.

Test Plan:
- Reset mid-line: assert RESET_n low while DE=1 and RGB=0xFFFFFF -> next cycle RGB=0, DE=0, HSYNC_n=VSYNC_n=1, YS=0.
- Latency: DELAY=3, DISP_IN/BLANK_IN=1/0 rising at tick 0, COLOR=0x7FFF -> DE and RGB=0xFFFFFF first appear after tick 4; HSYNC_IN_n low pulse of 2 ticks reproduced exactly 4 ticks later with width 2.
- Colour path:
  - COLOR=0x8000|(5'd16<<10)|(5'd1<<5)|5'd31 in display -> G=0x84, R=0x08, B=0xFF, YS=1.
  - Same word with DISP=0, BORDER=0x0000 -> RGB=0, YS=0, DE=1.
- Priority and hold: BLANK=DISP=1 -> RGB=0, DE=0. DCLK_EN held low 5 cycles with changing COLOR -> outputs frozen.
- START re-align: issue START coincident with DCLK_EN after 5 ticks -> no write that cycle, w=0, subsequent taps still emerge DELAY+1 ticks after input; index wrap across 8 ticks shows no glitch.
- With T9990_VOUT_SCANLINE_EN and SCANLINE=1: VS low then 2 HS pulses, COLOR=all-31 -> line 0 RGB=0xFFFFFF, line 1 RGB=0x7F7F7F, line 2 back to 0xFFFFFF.

Source files
------------

// File: rtl/t9990_video_out_pkg.sv
// ---------------------------------------------------------------------------
// T9990_REG : shared types and constants for the tiny9990 video output stage.
//
// Contents:
//   color_word_t   - palette colour word {ys, g[4:0], r[4:0], b[4:0]}
//   timing_t       - raster timing bundle {hs_n, vs_n, disp, blank}
//   VOUT_DLY_DEPTH - number of entries in the timing delay ring
//   TIMING_IDLE    - timing value that means "sync inactive, blanked"
//   expand5        - 5-bit to 8-bit colour component expansion
// ---------------------------------------------------------------------------
package T9990_REG;

    localparam int VOUT_DLY_DEPTH = 8;

    typedef struct packed {
        logic       ys;
        logic [4:0] g;
        logic [4:0] r;
        logic [4:0] b;
    } color_word_t;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic disp;
        logic blank;
    } timing_t;

    localparam timing_t TIMING_IDLE = timing_t'(4'b1101);

    // Replicating the top bits into the new LSBs maps 0 -> 0x00 and 31 -> 0xFF.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/t9990_video_out_if.sv
// ---------------------------------------------------------------------------
// t9990_video_out_if : registered video bus toward the encoder / HDMI block.
//
// Signals:
//   R_OUT, G_OUT, B_OUT - 8-bit colour components
//   HSYNC_n, VSYNC_n    - aligned syncs, active-low
//   DE                  - data enable (not blanked)
//   YS                  - superimpose / transparency flag
// Modports:
//   master - the video output stage (drives the bus)
//   slave  - the downstream encoder (observes the bus)
// ---------------------------------------------------------------------------
interface t9990_video_out_if;

    logic [7:0] R_OUT;
    logic [7:0] G_OUT;
    logic [7:0] B_OUT;
    logic       HSYNC_n;
    logic       VSYNC_n;
    logic       DE;
    logic       YS;

    modport master (
        output R_OUT, G_OUT, B_OUT, HSYNC_n, VSYNC_n, DE, YS
    );

    modport slave (
        input  R_OUT, G_OUT, B_OUT, HSYNC_n, VSYNC_n, DE, YS
    );

endinterface

// File: rtl/t9990_vout_delay.sv
// ---------------------------------------------------------------------------
// t9990_vout_delay : ring-buffer delay of the raster timing bundle.
//
// The ring is written at index w on every EN tick; the tap is read
// combinationally from w - DELAY, so a bundle written on one tick is
// presented on the tap DELAY ticks later. START rewinds w to 0 without
// writing and without clearing the ring.
//
// Parameters:
//   DELAY   - tap distance in EN ticks, legal 1..VOUT_DLY_DEPTH-1
// Ports:
//   CLK     - system clock
//   RESET_n - asynchronous active-low reset
//   EN      - advance enable (dot-clock enable)
//   START   - line start, rewinds the write index (wins over EN)
//   DIN     - timing bundle in
//   DOUT    - delayed timing bundle out
// ---------------------------------------------------------------------------
module t9990_vout_delay
    import T9990_REG::*;
#(
    parameter int DELAY = 3
) (
    input  logic    CLK,
    input  logic    RESET_n,
    input  logic    EN,
    input  logic    START,
    input  timing_t DIN,
    output timing_t DOUT
);

    localparam int IDX_W = $clog2(VOUT_DLY_DEPTH);

    timing_t            ring [VOUT_DLY_DEPTH];
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   r_idx;

    // Index arithmetic is modulo the ring size, so the 7 -> 0 wrap is free.
    assign r_idx = w_idx - IDX_W'(DELAY);
    assign DOUT  = ring[r_idx];

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            w_idx <= '0;
            for (int i = 0; i < VOUT_DLY_DEPTH; i++) begin
                ring[i] <= TIMING_IDLE;
            end
        end else if (START) begin
            w_idx <= '0;
        end else if (EN) begin
            ring[w_idx] <= DIN;
            w_idx       <= w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/t9990_video_out.sv
// ---------------------------------------------------------------------------
// t9990_video_out : tiny9990 output stage, downstream of the palette.
//
// Delays the raster timing to line up with the palette's colour output,
// substitutes the border colour outside the display window, forces black
// while blanked, expands 5-bit components to 8 bits and registers the
// result onto the video bus.
//
// Optional build macro T9990_VOUT_SCANLINE_EN adds a SCANLINE input that
// halves every component on odd lines (line parity follows aligned HS,
// cleared during aligned VS).
//
// Parameters:
//   DELAY      - palette latency in DCLK_EN ticks, legal 1..7
// Ports:
//   CLK        - system clock
//   RESET_n    - asynchronous active-low reset
//   DCLK_EN    - dot-clock enable; pixel state advances only when high
//   START      - line start, re-aligns the timing delay line
//   COLOR      - palette colour word {YS, G5, R5, B5}
//   BORDER     - border colour word, YS bit ignored
//   HSYNC_IN_n, VSYNC_IN_n, DISP_IN, BLANK_IN - timing, aligned with PA
//   SCANLINE   - scanline effect enable (only with T9990_VOUT_SCANLINE_EN)
//   vout       - registered RGB888 + HSYNC_n/VSYNC_n/DE/YS bus
// ---------------------------------------------------------------------------
module t9990_video_out
    import T9990_REG::*;
#(
    parameter int DELAY = 3
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              DCLK_EN,
    input  logic              START,
    input  logic [15:0]       COLOR,
    input  logic [15:0]       BORDER,
    input  logic              HSYNC_IN_n,
    input  logic              VSYNC_IN_n,
    input  logic              DISP_IN,
    input  logic              BLANK_IN,
`ifdef T9990_VOUT_SCANLINE_EN
    input  logic              SCANLINE,
`endif
    t9990_video_out_if.master vout
);

    timing_t     timing_in;
    timing_t     tap;
    color_word_t src;

    logic [7:0]  r_nxt, g_nxt, b_nxt;
    logic        ys_nxt, de_nxt;
    logic [7:0]  r_q, g_q, b_q;
    logic        hs_q, vs_q, de_q, ys_q;

    assign timing_in = '{hs_n: HSYNC_IN_n, vs_n: VSYNC_IN_n,
                         disp: DISP_IN,    blank: BLANK_IN};

    t9990_vout_delay #(
        .DELAY (DELAY)
    ) u_delay (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .EN      (DCLK_EN),
        .START   (START),
        .DIN     (timing_in),
        .DOUT    (tap)
    );

    // The border word has its YS bit masked off so border never superimposes.
    assign src = tap.disp ? color_word_t'(COLOR) : color_word_t'(BORDER & 16'h7FFF);

`ifdef T9990_VOUT_SCANLINE_EN
    logic line_odd, line_odd_nxt, hs_prev;

    // Parity is computed for the current tick so the pixel on the HS edge
    // already belongs to the new line.
    always_comb begin
        line_odd_nxt = line_odd;
        if (!tap.vs_n) begin
            line_odd_nxt = 1'b0;
        end else if (hs_prev && !tap.hs_n) begin
            line_odd_nxt = ~line_odd;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            line_odd <= 1'b0;
            hs_prev  <= 1'b1;
        end else if (DCLK_EN) begin
            line_odd <= line_odd_nxt;
            hs_prev  <= tap.hs_n;
        end
    end
`endif

    // Blank overrides the display window; outside the window the border shows.
    always_comb begin
        r_nxt  = 8'h00;
        g_nxt  = 8'h00;
        b_nxt  = 8'h00;
        ys_nxt = 1'b0;
        de_nxt = 1'b0;
        if (!tap.blank) begin
            r_nxt  = expand5(src.r);
            g_nxt  = expand5(src.g);
            b_nxt  = expand5(src.b);
            ys_nxt = src.ys;
            de_nxt = 1'b1;
`ifdef T9990_VOUT_SCANLINE_EN
            if (SCANLINE && line_odd_nxt) begin
                r_nxt = r_nxt >> 1;
                g_nxt = g_nxt >> 1;
                b_nxt = b_nxt >> 1;
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_q  <= 8'h00;
            g_q  <= 8'h00;
            b_q  <= 8'h00;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            de_q <= 1'b0;
            ys_q <= 1'b0;
        end else if (DCLK_EN) begin
            r_q  <= r_nxt;
            g_q  <= g_nxt;
            b_q  <= b_nxt;
            hs_q <= tap.hs_n;
            vs_q <= tap.vs_n;
            de_q <= de_nxt;
            ys_q <= ys_nxt;
        end
    end

    assign vout.R_OUT   = r_q;
    assign vout.G_OUT   = g_q;
    assign vout.B_OUT   = b_q;
    assign vout.HSYNC_n = hs_q;
    assign vout.VSYNC_n = vs_q;
    assign vout.DE      = de_q;
    assign vout.YS      = ys_q;

endmodule

// File: tb/tb_t9990_video_out.sv
// ---------------------------------------------------------------------------
// tb_t9990_video_out : self-checking bench for t9990_video_out.
//
// A behavioural reference model keeps the timing history as an 8-slot
// array addressed by a write position and computes the expected output
// word {R,G,B,HS,VS,DE,YS} from the colour rules with plain arithmetic.
// With T9990_VOUT_SCANLINE_EN defined, the scanline scenario is added.
// ---------------------------------------------------------------------------
module tb_t9990_video_out;
    import T9990_REG::*;

    localparam int DELAY = 3;

    logic        CLK        = 1'b0;
    logic        RESET_n    = 1'b0;
    logic        DCLK_EN    = 1'b0;
    logic        START      = 1'b0;
    logic [15:0] COLOR      = 16'h0000;
    logic [15:0] BORDER     = 16'h0000;
    logic        HSYNC_IN_n = 1'b1;
    logic        VSYNC_IN_n = 1'b1;
    logic        DISP_IN    = 1'b0;
    logic        BLANK_IN   = 1'b1;
`ifdef T9990_VOUT_SCANLINE_EN
    logic        SCANLINE   = 1'b0;
`endif

    t9990_video_out_if vout_if ();

    t9990_video_out #(
        .DELAY (DELAY)
    ) dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .DCLK_EN    (DCLK_EN),
        .START      (START),
        .COLOR      (COLOR),
        .BORDER     (BORDER),
        .HSYNC_IN_n (HSYNC_IN_n),
        .VSYNC_IN_n (VSYNC_IN_n),
        .DISP_IN    (DISP_IN),
        .BLANK_IN   (BLANK_IN),
`ifdef T9990_VOUT_SCANLINE_EN
        .SCANLINE   (SCANLINE),
`endif
        .vout       (vout_if)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    // Reference model state: timing history {hs,vs,disp,blank} per slot.
    logic [3:0]  m_hist [8];
    int          m_pos;
    logic [27:0] m_out;
    logic        m_par;
    logic        m_hs_prev;

    function automatic logic [7:0] exp5(input logic [4:0] c);
        int v;
        v = int'(c) * 8 + int'(c) / 4;
        return v[7:0];
    endfunction

    function automatic logic [27:0] dut_out();
        return {vout_if.R_OUT, vout_if.G_OUT, vout_if.B_OUT,
                vout_if.HSYNC_n, vout_if.VSYNC_n, vout_if.DE, vout_if.YS};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_hist[i] = 4'b1101;
        m_pos     = 0;
        m_out     = {24'h000000, 4'b1100};
        m_par     = 1'b0;
        m_hs_prev = 1'b1;
    endtask

    task automatic model_tick(input logic en, input logic st);
        logic [3:0] d;
        logic [7:0] r, g, b;
        logic       ys, de, par_n;
        d = m_hist[(m_pos - DELAY + 8) % 8];
        if (en) begin
            r = 0; g = 0; b = 0; ys = 0; de = 0;
            if (!d[0]) begin
                de = 1;
                if (d[1]) begin
                    r = exp5(COLOR[9:5]); g = exp5(COLOR[14:10]); b = exp5(COLOR[4:0]);
                    ys = COLOR[15];
                end else begin
                    r = exp5(BORDER[9:5]); g = exp5(BORDER[14:10]); b = exp5(BORDER[4:0]);
                end
            end
            par_n = m_par;
            if (!d[2]) par_n = 1'b0;
            else if (m_hs_prev && !d[3]) par_n = ~m_par;
`ifdef T9990_VOUT_SCANLINE_EN
            if (SCANLINE && par_n) begin
                r = r / 2; g = g / 2; b = b / 2;
            end
`endif
            m_par     = par_n;
            m_hs_prev = d[3];
            m_out     = {r, g, b, d[3], d[2], de, ys};
        end
        if (st) begin
            m_pos = 0;
        end else if (en) begin
            m_hist[m_pos] = {HSYNC_IN_n, VSYNC_IN_n, DISP_IN, BLANK_IN};
            m_pos = (m_pos + 1) % 8;
        end
    endtask

    // One clock with the given enables; model advances with the sampled inputs.
    task automatic applyStimulus(input logic en, input logic st);
        DCLK_EN = en;
        START   = st;
        @(posedge CLK);
        #1;
        model_tick(en, st);
        DCLK_EN = 1'b0;
        START   = 1'b0;
    endtask

    task automatic set_timing(input logic hs, input logic vs, input logic disp, input logic blank);
        HSYNC_IN_n = hs; VSYNC_IN_n = vs; DISP_IN = disp; BLANK_IN = blank;
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        model_reset();
        applyStimulus(1'b1, 1'b0);
        model_reset();
        checks++;
        if (dut_out() !== 28'h000000C) $display("[TB] FAIL reset_state actual=%h required=%h", dut_out(), 28'h000000C);
        else passed++;
        RESET_n = 1'b1;
        set_timing(1, 1, 1, 0);
        COLOR = 16'h7FFF;
        for (int k = 0; k < DELAY + 2; k++) applyStimulus(1'b1, 1'b0);
        checks++;
        if (dut_out() !== 28'hFFFFFFE) $display("[TB] FAIL reset_preload actual=%h required=%h", dut_out(), 28'hFFFFFFE);
        else passed++;
        @(posedge CLK);
        #2;
        RESET_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_out() !== 28'h000000C) $display("[TB] FAIL reset_midline actual=%h required=%h", dut_out(), 28'h000000C);
        else passed++;
        @(negedge CLK);
        RESET_n = 1'b1;
        set_timing(1, 1, 0, 1);
    endtask

    task automatic test_latency();
        int first_de, first_hs, hs_width;
        set_timing(1, 1, 0, 1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0);
        set_timing(1, 1, 1, 0);
        COLOR = 16'h7FFF;
        first_de = -1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0);
            checks++;
            if (dut_out() !== m_out) $display("[TB] FAIL latency_de_tick%0d actual=%h required=%h", k, dut_out(), m_out);
            else passed++;
            if (first_de < 0 && vout_if.DE === 1'b1 && {vout_if.R_OUT, vout_if.G_OUT, vout_if.B_OUT} === 24'hFFFFFF)
                first_de = k;
        end
        checks++;
        if (first_de !== DELAY + 1) $display("[TB] FAIL latency_de actual=%0d required=%0d", first_de, DELAY + 1);
        else passed++;
        first_hs = -1;
        hs_width = 0;
        for (int k = 1; k <= 10; k++) begin
            HSYNC_IN_n = (k <= 2) ? 1'b0 : 1'b1;
            applyStimulus(1'b1, 1'b0);
            if (vout_if.HSYNC_n === 1'b0) begin
                hs_width++;
                if (first_hs < 0) first_hs = k;
            end
        end
        checks++;
        if (first_hs !== DELAY + 1 || hs_width !== 2)
            $display("[TB] FAIL latency_hs actual=start%0d/width%0d required=start%0d/width2", first_hs, hs_width, DELAY + 1);
        else passed++;
    endtask

    task automatic test_color();
        set_timing(1, 1, 1, 0);
        COLOR = 16'h8000 | (16'd16 << 10) | (16'd1 << 5) | 16'd31;
        for (int k = 0; k < DELAY + 2; k++) applyStimulus(1'b1, 1'b0);
        checks++;
        if (dut_out() !== {8'h08, 8'h84, 8'hFF, 4'b1111}) $display("[TB] FAIL color_expand actual=%h required=%h", dut_out(), {8'h08, 8'h84, 8'hFF, 4'b1111});
        else passed++;
        DISP_IN = 1'b0;
        BORDER  = 16'h0000;
        for (int k = 0; k < DELAY + 2; k++) applyStimulus(1'b1, 1'b0);
        checks++;
        if (dut_out() !== {24'h000000, 4'b1110}) $display("[TB] FAIL color_border_black actual=%h required=%h", dut_out(), {24'h000000, 4'b1110});
        else passed++;
        for (int n = 0; n < 6; n++) begin
            BORDER = 16'($urandom);
            COLOR  = 16'($urandom);
            DISP_IN = n[0];
            for (int k = 0; k < DELAY + 2; k++) applyStimulus(1'b1, 1'b0);
            checks++;
            if (dut_out() !== m_out) $display("[TB] FAIL color_random%0d actual=%h required=%h", n, dut_out(), m_out);
            else passed++;
        end
    endtask

    task automatic test_priority_hold();
        logic [27:0] held;
        set_timing(1, 1, 1, 1);
        COLOR = 16'hFFFF;
        BORDER = 16'h7FFF;
        for (int k = 0; k < DELAY + 2; k++) applyStimulus(1'b1, 1'b0);
        checks++;
        if (dut_out() !== {24'h000000, 4'b1100}) $display("[TB] FAIL blank_priority actual=%h required=%h", dut_out(), {24'h000000, 4'b1100});
        else passed++;
        set_timing(1, 1, 1, 0);
        COLOR = 16'($urandom) | 16'h0421;
        for (int k = 0; k < DELAY + 2; k++) applyStimulus(1'b1, 1'b0);
        held = m_out;
        for (int k = 0; k < 5; k++) begin
            COLOR = 16'($urandom);
            set_timing(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            applyStimulus(1'b0, 1'b0);
            checks++;
            if (dut_out() !== held) $display("[TB] FAIL hold_tick%0d actual=%h required=%h", k, dut_out(), held);
            else passed++;
        end
    endtask

    task automatic test_start();
        int first_de, de_drops;
        set_timing(1, 1, 0, 1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0);
        set_timing(1, 1, 1, 0);
        COLOR = 16'h7FFF;
        applyStimulus(1'b1, 1'b1);
        first_de = -1;
        de_drops = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b0);
            checks++;
            if (dut_out() !== m_out) $display("[TB] FAIL start_tick%0d actual=%h required=%h", k, dut_out(), m_out);
            else passed++;
            if (first_de < 0 && vout_if.DE === 1'b1) first_de = k;
            else if (first_de >= 0 && vout_if.DE !== 1'b1) de_drops++;
        end
        checks++;
        if (first_de !== DELAY + 1 || de_drops !== 0)
            $display("[TB] FAIL start_realign actual=start%0d/drops%0d required=start%0d/drops0", first_de, de_drops, DELAY + 1);
        else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            COLOR  = 16'($urandom);
            BORDER = 16'($urandom);
            set_timing(1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) == 0);
            applyStimulus(($urandom % 4) != 0, ($urandom % 24) == 0);
            checks++;
            if (dut_out() !== m_out) $display("[TB] FAIL random_tick%0d actual=%h required=%h", k, dut_out(), m_out);
            else passed++;
        end
    endtask

`ifdef T9990_VOUT_SCANLINE_EN
    task automatic test_scanline();
        int halved;
        SCANLINE = 1'b1;
        COLOR = 16'h7FFF;
        set_timing(1, 0, 1, 0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0);
        halved = 0;
        for (int k = 0; k < 30; k++) begin
            set_timing((k % 10) < 2 && k >= 10 ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);
            applyStimulus(1'b1, 1'b0);
            checks++;
            if (dut_out() !== m_out) $display("[TB] FAIL scanline_tick%0d actual=%h required=%h", k, dut_out(), m_out);
            else passed++;
            if ({vout_if.R_OUT, vout_if.G_OUT, vout_if.B_OUT} === 24'h7F7F7F) halved++;
        end
        checks++;
        if (halved !== 10) $display("[TB] FAIL scanline_odd_line actual=%0d required=10", halved);
        else passed++;
        SCANLINE = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_color();
        test_priority_hold();
        test_start();
        test_random();
`ifdef T9990_VOUT_SCANLINE_EN
        test_scanline();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
